// File: rtl/riscv_result_checker.sv
// Self-check monitor: shadows a block of integer registers from both writeback ports and,
// after the end-of-test CSR write plus a settle window, scores them against expected values.
module riscv_result_checker #(
   parameter int unsigned NUM_CHECKS     = 15,
   parameter int unsigned FIRST_REG      = 10,
   parameter int unsigned XLEN           = 32,
   parameter int unsigned SETTLE_CYCLES  = 10,
   parameter int unsigned TIMEOUT_CYCLES = 10000
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            start_i,
   input  logic                            wb0_valid_i,
   input  logic [4:0]                      wb0_rd_i,
   input  logic [XLEN-1:0]                 wb0_value_i,
   input  logic                            wb1_valid_i,
   input  logic [4:0]                      wb1_rd_i,
   input  logic [XLEN-1:0]                 wb1_value_i,
   input  logic                            opcode_valid_i,
   input  logic [31:0]                     opcode_opcode_i,
   input  logic [NUM_CHECKS*XLEN-1:0]      exp_values_i,
   output logic                            done_o,
   output logic                            pass_o,
   output logic                            timeout_o,
   output logic [NUM_CHECKS-1:0]           fail_mask_o,
   output logic [$clog2(NUM_CHECKS+1)-1:0] pass_count_o,
   output logic [4:0]                      first_fail_o
);

   localparam int unsigned PC_W    = $clog2(NUM_CHECKS + 1);
   localparam int unsigned IDX_W   = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
   localparam int unsigned MAX_A   = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
   localparam int unsigned CNT_MAX = (MAX_A > NUM_CHECKS) ? MAX_A : NUM_CHECKS;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CMP_LEN     = CNT_W'(NUM_CHECKS);

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      SETTLE,
      COMPARE,
      DONE
   } state_t;

   state_t                          state;
   state_t                          state_next;
   logic [CNT_W-1:0]                cnt;
   logic [NUM_CHECKS-1:0][XLEN-1:0] shadow;
   logic [NUM_CHECKS-1:0][XLEN-1:0] exp_arr;
   logic [NUM_CHECKS-1:0]           written;
   logic                            trigger;
   logic                            arm;
   logic                            capture;
   logic                            cmp_active;
   logic                            check_ok;
   logic [IDX_W-1:0]                idx;
   logic                            unused_opcode;

   assign unused_opcode = ^{opcode_opcode_i[31:15], opcode_opcode_i[11:7]};
   assign exp_arr       = exp_values_i;

   // End-of-test marker: SYSTEM major opcode with funct3 = CSRRW
   assign trigger    = opcode_valid_i && (opcode_opcode_i[6:0] == 7'b1110011)
                       && (opcode_opcode_i[14:12] == 3'b001);
   assign arm        = start_i && ((state == IDLE) || (state == DONE));
   assign capture    = (state == RUN) || (state == SETTLE);
   assign cmp_active = (state == COMPARE) && (cnt < CMP_LEN);
   assign idx        = cnt[IDX_W-1:0];
   assign check_ok   = written[idx] && (shadow[idx] == exp_arr[idx]);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_next;
   end

   // COMPARE holds one extra cycle after the last index so pass_o sees the final mask
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start_i) state_next = RUN;
         RUN: begin
            if (trigger)              state_next = SETTLE;
            else if (cnt == RUN_LAST) state_next = DONE;
         end
         SETTLE:  if (cnt == SETTLE_LAST) state_next = COMPARE;
         COMPARE: if (cnt == CMP_LEN)     state_next = DONE;
         DONE:    if (start_i) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                                   cnt <= '0;
      else if ((state_next != state) || (state == IDLE) || (state == DONE)) cnt <= '0;
      else                                                           cnt <= cnt + CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shadow  <= '0;
         written <= '0;
      end else if (arm) begin
         shadow  <= '0;
         written <= '0;
      end else if (capture) begin
         for (int unsigned k = 0; k < NUM_CHECKS; k++) begin
            // wb1 is the younger slot: its update is applied last and wins a collision
            if (wb0_valid_i && (wb0_rd_i == 5'(FIRST_REG + k))) begin
               shadow[k]  <= wb0_value_i;
               written[k] <= 1'b1;
            end
            if (wb1_valid_i && (wb1_rd_i == 5'(FIRST_REG + k))) begin
               shadow[k]  <= wb1_value_i;
               written[k] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         done_o       <= 1'b0;
         pass_o       <= 1'b0;
         timeout_o    <= 1'b0;
         fail_mask_o  <= '0;
         pass_count_o <= '0;
         first_fail_o <= '0;
      end else if (arm) begin
         done_o       <= 1'b0;
         pass_o       <= 1'b0;
         timeout_o    <= 1'b0;
         fail_mask_o  <= '0;
         pass_count_o <= '0;
         first_fail_o <= '0;
      end else if ((state == RUN) && (state_next == DONE)) begin
         done_o      <= 1'b1;
         timeout_o   <= 1'b1;
         fail_mask_o <= '1;
      end else if (cmp_active) begin
         if (check_ok) begin
            pass_count_o <= pass_count_o + PC_W'(1);
         end else begin
            fail_mask_o[idx] <= 1'b1;
            if (fail_mask_o == '0) first_fail_o <= 5'(idx);
         end
      end else if (state == COMPARE) begin
         done_o <= 1'b1;
         pass_o <= (fail_mask_o == '0);
      end
   end

endmodule
